// File: rtl/lc3b_types.sv
// Types shared between the L1 cache controller and its datapath.
package lc3b_types;

   typedef enum logic {
      CPU  = 1'b0,
      PMEM = 1'b1
   } lc3b_L1_datasel;

   typedef logic [2:0] lc3b_L1_index;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for a direct-mapped, write-back, write-allocate L1 cache.
//   state       | meaning
//   S_IDLE      | serve hits; on a miss pick writeback or allocate
//   S_WRITEBACK | write the dirty victim line to physical memory
//   S_ALLOCATE  | fetch the missing line from physical memory into the arrays
module l1_cache_control
   import lc3b_types::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 hit,
   input  logic                 dirty,
   input  logic                 pmem_resp,
   output logic                 mem_resp,
   output logic                 load_data,
   output logic                 load_tag,
   output logic                 load_valid,
   output logic                 load_dirty,
   output logic                 dirty_in,
   output lc3b_L1_datasel       data_sel,
   output logic                 pmem_addr_sel,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t state, state_next;
   logic   post_fill;
   logic   fill_done;
   logic   hit_inc;
   logic   miss_inc;
   logic   req;

   assign req = mem_read | mem_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         post_fill <= 1'b0;
      end else begin
         state     <= state_next;
         post_fill <= fill_done;
      end
   end

   always_comb begin
      state_next    = state;
      mem_resp      = 1'b0;
      load_data     = 1'b0;
      load_tag      = 1'b0;
      load_valid    = 1'b0;
      load_dirty    = 1'b0;
      dirty_in      = 1'b0;
      data_sel      = CPU;
      pmem_addr_sel = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      fill_done     = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;

      case (state)
         S_IDLE: begin
            if (req) begin
               if (hit) begin
                  mem_resp = 1'b1;
                  // a write wins over a simultaneous read
                  if (mem_write) begin
                     load_data  = 1'b1;
                     load_dirty = 1'b1;
                     dirty_in   = 1'b1;
                  end
                  // the re-check right after a fill is the tail of a miss
                  hit_inc = ~post_fill;
               end else begin
                  miss_inc   = 1'b1;
                  state_next = dirty ? S_WRITEBACK : S_ALLOCATE;
               end
            end
         end

         S_WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            if (pmem_resp) begin
               state_next = S_ALLOCATE;
            end
         end

         S_ALLOCATE: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_data  = 1'b1;
               load_tag   = 1'b1;
               load_valid = 1'b1;
               load_dirty = 1'b1;
               data_sel   = PMEM;
               fill_done  = 1'b1;
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // keep memory requests and array writes quiet while reset is held
      if (!reset_n) begin
         mem_resp      = 1'b0;
         load_data     = 1'b0;
         load_tag      = 1'b0;
         load_valid    = 1'b0;
         load_dirty    = 1'b0;
         dirty_in      = 1'b0;
         data_sel      = CPU;
         pmem_addr_sel = 1'b0;
         pmem_read     = 1'b0;
         pmem_write    = 1'b0;
         fill_done     = 1'b0;
         hit_inc       = 1'b0;
         miss_inc      = 1'b0;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (hit_inc),
      .count   (hit_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (miss_inc),
      .count   (miss_count)
   );

endmodule

// File: tb/tb_l1_cache_control.sv
// Directed bench for l1_cache_control: IDLE decode table plus miss/reset/saturation sequences.
module tb_l1_cache_control;
   import lc3b_types::*;

   logic clk;
   logic reset_n;
   logic mem_read, mem_write, hit, dirty, pmem_resp;

   logic           mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in;
   lc3b_L1_datasel data_sel;
   logic           pmem_addr_sel, pmem_read, pmem_write;
   logic [15:0]    hit_count, miss_count;

   logic           u4_mem_resp, u4_load_data, u4_load_tag, u4_load_valid, u4_load_dirty, u4_dirty_in;
   lc3b_L1_datasel u4_data_sel;
   logic           u4_pmem_addr_sel, u4_pmem_read, u4_pmem_write;
   logic [3:0]     u4_hit_count, u4_miss_count;

   l1_cache_control dut (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
      .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
      .load_dirty(load_dirty), .dirty_in(dirty_in), .data_sel(data_sel),
      .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   l1_cache_control #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .mem_resp(u4_mem_resp),
      .load_data(u4_load_data), .load_tag(u4_load_tag), .load_valid(u4_load_valid),
      .load_dirty(u4_load_dirty), .dirty_in(u4_dirty_in), .data_sel(u4_data_sel),
      .pmem_addr_sel(u4_pmem_addr_sel), .pmem_read(u4_pmem_read), .pmem_write(u4_pmem_write),
      .hit_count(u4_hit_count), .miss_count(u4_miss_count)
   );

   // {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in, data_sel, pmem_addr_sel, pmem_read, pmem_write}
   logic [9:0] outs;
   assign outs = {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
                  logic'(data_sel), pmem_addr_sel, pmem_read, pmem_write};

   localparam logic [9:0] O_NONE   = 10'b0000000000;
   localparam logic [9:0] O_RDHIT  = 10'b1000000000;
   localparam logic [9:0] O_WRHIT  = 10'b1100110000;
   localparam logic [9:0] O_WB     = 10'b0000000101;
   localparam logic [9:0] O_ALLOC  = 10'b0000000010;
   localparam logic [9:0] O_FILL   = 10'b0111101010;

   typedef struct {
      logic       rd;
      logic       wr;
      logic       h;
      logic       d;
      logic       presp;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[9];

   int total  = 0;
   int passed = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      hit       = 1'b0;
      dirty     = 1'b0;
      pmem_resp = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      clear_inputs();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int  rcnt;
      bit  done;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_RDHIT};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_WRHIT};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_WRHIT};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_NONE};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_NONE};
      vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, O_RDHIT};

      // reset state, with a would-be hit presented while reset is held
      clear_inputs();
      reset_n = 1'b0;
      #1;
      chk("reset_outs", 32'(outs), 32'(O_NONE));
      chk("reset_hit_count", 32'(hit_count), 32'd0);
      chk("reset_miss_count", 32'(miss_count), 32'd0);
      mem_read = 1'b1;
      hit      = 1'b1;
      #1;
      chk("reset_quiet_resp", 32'(outs), 32'(O_NONE));
      clear_inputs();
      tick();
      reset_n = 1'b1;
      tick();

      // IDLE decode table; request withdrawn before each edge so state stays IDLE
      foreach (vecs[i]) begin
         mem_read  = vecs[i].rd;
         mem_write = vecs[i].wr;
         hit       = vecs[i].h;
         dirty     = vecs[i].d;
         pmem_resp = vecs[i].presp;
         #1;
         chk($sformatf("idle_vec%0d", i), 32'(outs), 32'(vecs[i].exp));
         clear_inputs();
         tick();
      end
      chk("table_hit_count", 32'(hit_count), 32'd0);
      chk("table_miss_count", 32'(miss_count), 32'd0);

      // read hit across a clock edge
      do_reset();
      mem_read = 1'b1;
      hit      = 1'b1;
      #1;
      chk("rdhit_outs", 32'(outs), 32'(O_RDHIT));
      tick();
      clear_inputs();
      chk("rdhit_hit_count", 32'(hit_count), 32'd1);
      chk("rdhit_miss_count", 32'(miss_count), 32'd0);

      // clean read miss, fill answered on the third pmem_read cycle
      do_reset();
      mem_read = 1'b1;
      #1;
      chk("clean_miss_idle", 32'(outs), 32'(O_NONE));
      tick();
      chk("clean_miss_count", 32'(miss_count), 32'd1);
      rcnt = 0;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (pmem_read) rcnt++;
         if (rcnt == 3) begin
            pmem_resp = 1'b1;
            #1;
            chk("clean_fill_outs", 32'(outs), 32'(O_FILL));
            done = 1'b1;
         end
         tick();
      end
      pmem_resp = 1'b0;
      chk("clean_fill_done", 32'(done), 32'd1);
      chk("clean_pmem_read_cycles", 32'(rcnt), 32'd3);
      hit = 1'b1;
      #1;
      chk("clean_recheck_outs", 32'(outs), 32'(O_RDHIT));
      tick();
      clear_inputs();
      chk("clean_hit_count", 32'(hit_count), 32'd0);
      chk("clean_miss_count_end", 32'(miss_count), 32'd1);

      // dirty write miss: writeback, fill, then the write lands on the re-check
      do_reset();
      mem_write = 1'b1;
      dirty     = 1'b1;
      tick();
      chk("dwm_wb1", 32'(outs), 32'(O_WB));
      tick();
      chk("dwm_wb2", 32'(outs), 32'(O_WB));
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("dwm_alloc", 32'(outs), 32'(O_ALLOC));
      pmem_resp = 1'b1;
      #1;
      chk("dwm_fill", 32'(outs), 32'(O_FILL));
      tick();
      pmem_resp = 1'b0;
      hit       = 1'b1;
      dirty     = 1'b0;
      #1;
      chk("dwm_write_hit", 32'(outs), 32'(O_WRHIT));
      tick();
      clear_inputs();
      chk("dwm_miss_count", 32'(miss_count), 32'd1);
      chk("dwm_hit_count", 32'(hit_count), 32'd0);

      // CPU drops its request mid-miss
      do_reset();
      mem_read = 1'b1;
      dirty    = 1'b1;
      tick();
      mem_read = 1'b0;
      dirty    = 1'b0;
      #1;
      chk("drop_wb", 32'(outs), 32'(O_WB));
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("drop_alloc", 32'(outs), 32'(O_ALLOC));
      pmem_resp = 1'b1;
      #1;
      chk("drop_fill", 32'(outs), 32'(O_FILL));
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("drop_idle", 32'(outs), 32'(O_NONE));
      chk("drop_miss_count", 32'(miss_count), 32'd1);

      // asynchronous reset during writeback
      do_reset();
      mem_write = 1'b1;
      dirty     = 1'b1;
      tick();
      chk("rstwb_pmem_write", 32'(pmem_write), 32'd1);
      chk("rstwb_miss_before", 32'(miss_count), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rstwb_pmem_write_async", 32'(pmem_write), 32'd0);
      chk("rstwb_miss_async", 32'(miss_count), 32'd0);
      hit = 1'b1;
      #1;
      chk("rstwb_quiet", 32'(outs), 32'(O_NONE));
      clear_inputs();
      tick();
      reset_n = 1'b1;
      #1;
      chk("rstwb_idle_outs", 32'(outs), 32'(O_NONE));
      mem_read = 1'b1;
      hit      = 1'b1;
      #1;
      chk("rstwb_idle_hit", 32'(outs), 32'(O_RDHIT));
      clear_inputs();
      tick();
      chk("rstwb_hit_count", 32'(hit_count), 32'd0);
      chk("rstwb_miss_count", 32'(miss_count), 32'd0);

      // 20 consecutive read hits: the 4-bit instance must hold at 15
      do_reset();
      mem_read = 1'b1;
      hit      = 1'b1;
      repeat (20) tick();
      clear_inputs();
      chk("sat_hit_count4", 32'(u4_hit_count), 32'd15);
      chk("sat_miss_count4", 32'(u4_miss_count), 32'd0);
      chk("sat_hit_count16", 32'(hit_count), 32'd20);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
